// File: rtl/lsu_pkg.sv
// LSU shared types: FSM states, op codes, latched-op bundle
// and the op legality check used at accept time.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_state_t;

    localparam logic [2:0] OP_B  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_W  = 3'd2;
    localparam logic [2:0] OP_BU = 3'd4;
    localparam logic [2:0] OP_HU = 3'd5;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] off;
    } lsu_op_t;

    function automatic logic is_legal_op(
        input logic       wen,
        input logic [2:0] op
    );
        logic ok;
        if (wen) begin
            ok = (op == OP_B) || (op == OP_H) || (op == OP_W);
        end else begin
            ok = (op == OP_B) || (op == OP_H) || (op == OP_W)
              || (op == OP_BU) || (op == OP_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store shift/mask, load extract/extend.
// Ports: op, addr (byte offset), wdata, word (raw) -> mem_wdata, wmask, rdata, misaligned.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] mem_wdata,
    output logic [7:0]  wmask,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [3:0]  m4;

    always_comb begin
        sh        = {addr, 3'b000};
        mem_wdata = wdata << sh;
        lane      = word >> sh;
        m4        = 4'h0;
        unique case (1'b1)
            (op[1:0] == 2'd0): m4 = 4'h1 << addr;
            (op[1:0] == 2'd1): m4 = 4'h3 << addr;
            (op[1:0] == 2'd2): m4 = 4'hF;
            default:           m4 = 4'h0;
        endcase
        // Upper nibble is unused lane space and stays zero
        wmask = {4'h0, m4};

        misaligned = ((op[1:0] == 2'd1) && addr[0])
                  || ((op[1:0] == 2'd2) && (addr != 2'd0));

        rdata = 32'h0;
        unique case (op)
            OP_B:    rdata = {{24{lane[7]}}, lane[7:0]};
            OP_H:    rdata = {{16{lane[15]}}, lane[15:0]};
            OP_W:    rdata = word;
            OP_BU:   rdata = {24'h0, lane[7:0]};
            OP_HU:   rdata = {16'h0, lane[15:0]};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_req.sv
// LSU memory initiator: one op in flight, EXU -> responder -> WBU.
// Ports: in_* (EXU op), mem_* (request/response), out_* (WBU result).
module lsu_mem_req
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    lsu_state_t      state;
    lsu_op_t         cur;
    logic [TO_W-1:0] cnt;

    logic [2:0]  a_op;
    logic [1:0]  a_off;
    logic [31:0] a_wdata;
    logic [7:0]  a_wmask;
    logic [31:0] a_rdata;
    logic        a_mis;

    // Accept-time decode uses live inputs; extraction uses the latched op
    assign a_op  = (state == IDLE) ? in_op : cur.op;
    assign a_off = (state == IDLE) ? in_addr[1:0] : cur.off;

    lsu_align u_align (
        .op         (a_op),
        .addr       (a_off),
        .wdata      (in_wdata),
        .word       (mem_resp_rdata),
        .mem_wdata  (a_wdata),
        .wmask      (a_wmask),
        .rdata      (a_rdata),
        .misaligned (a_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur           <= '0;
            cnt           <= '0;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
            mem_wmask     <= 8'h0;
            out_valid     <= 1'b0;
            out_rdata     <= 32'h0;
            out_err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur.op    <= in_op;
                        cur.off   <= in_addr[1:0];
                        mem_wen   <= in_wen;
                        mem_addr  <= {in_addr[31:2], 2'b00};
                        mem_wdata <= in_wen ? a_wdata : 32'h0;
                        mem_wmask <= in_wen ? a_wmask : 8'h0;
                        in_ready  <= 1'b0;
                        if (!is_legal_op(in_wen, in_op) || a_mis) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_rdata <= 32'h0;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    cnt <= cnt + 1'b1;
                    if (mem_resp_valid) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        out_rdata <= mem_wen ? 32'h0 : a_rdata;
                    end else if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        out_rdata <= 32'h0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        out_rdata <= 32'h0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
